// File: rtl/prng_arbiter.sv
// Round-robin arbiter sharing one PRNG byte source among N requesters.
// Optional FILL watchdog (err port, generator re-reset) enabled by PRNG_ARB_TIMEOUT_EN.
module prng_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         res,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic [N-1:0] valid,
  output logic [7:0]   dout,
  output logic         prng_ena,
  output logic         prng_res,
`ifdef PRNG_ARB_TIMEOUT_EN
  output logic         err,
`endif
  input  logic [7:0]   prng_dout,
  input  logic         prng_done
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  if (N < 2 || N > 8 || TIMEOUT < 48 || TIMEOUT > 255) begin : g_bad_cfg
    $error("prng_arbiter: N must be 2..8 and TIMEOUT 48..255");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    DELIVER = 2'd2
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [N-1:0]   r_gnt, w_gnt_nxt;
  logic [PW-1:0]  r_widx, w_widx_nxt;
  logic [PW-1:0]  r_ptr, w_ptr_nxt;
  logic [7:0]     r_dout, w_dout_nxt;
  logic           r_ena, w_ena_nxt;
  logic           r_prng_res, w_prng_res_nxt;
  logic           r_done_q;
  logic           w_byte_evt;
  logic           w_found;
  logic [PW-1:0]  w_win;

`ifdef PRNG_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0]     r_cnt, w_cnt_nxt;
  logic           r_err, w_err_nxt;
`endif

  // Only a rising edge of done counts, so a level left high from an earlier
  // enable window can never be mistaken for a fresh byte.
  assign w_byte_evt = prng_done & ~r_done_q;

  always_comb begin
    int idx;
    w_found = 1'b0;
    w_win   = '0;
    idx     = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(r_ptr) + i) % N;
      if (!w_found && req[PW'(idx)]) begin
        w_found = 1'b1;
        w_win   = PW'(idx);
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_widx_nxt     = r_widx;
    w_ptr_nxt      = r_ptr;
    w_dout_nxt     = r_dout;
    w_ena_nxt      = r_ena;
    w_prng_res_nxt = 1'b0;
`ifdef PRNG_ARB_TIMEOUT_EN
    w_cnt_nxt      = r_cnt;
    w_err_nxt      = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        w_ena_nxt = 1'b0;
        // Hold off while the generator is still being reset.
        if (w_found && !r_prng_res) begin
          w_state_nxt = FILL;
          w_gnt_nxt   = {{(N-1){1'b0}}, 1'b1} << w_win;
          w_widx_nxt  = w_win;
          w_ena_nxt   = 1'b1;
`ifdef PRNG_ARB_TIMEOUT_EN
          w_cnt_nxt   = 8'd0;
`endif
        end
      end
      FILL: begin
`ifdef PRNG_ARB_TIMEOUT_EN
        w_cnt_nxt = r_cnt + 8'd1;
`endif
        if (w_byte_evt) begin
          w_dout_nxt  = prng_dout;
          w_ena_nxt   = 1'b0;
          w_state_nxt = DELIVER;
        end
`ifdef PRNG_ARB_TIMEOUT_EN
        else if (r_cnt == TO_LAST) begin
          w_err_nxt      = 1'b1;
          w_prng_res_nxt = 1'b1;
          w_gnt_nxt      = '0;
          w_ptr_nxt      = r_widx;
          w_ena_nxt      = 1'b0;
          w_state_nxt    = IDLE;
        end
`endif
      end
      DELIVER: begin
        w_gnt_nxt   = '0;
        w_ptr_nxt   = r_widx;
        w_ena_nxt   = 1'b0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_gnt_nxt   = '0;
        w_ena_nxt   = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_widx     <= '0;
      r_ptr      <= PW'(N - 1);
      r_dout     <= 8'h00;
      r_ena      <= 1'b0;
      r_prng_res <= 1'b1;
      r_done_q   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_widx     <= w_widx_nxt;
      r_ptr      <= w_ptr_nxt;
      r_dout     <= w_dout_nxt;
      r_ena      <= w_ena_nxt;
      r_prng_res <= w_prng_res_nxt;
      r_done_q   <= prng_done;
    end
  end

`ifdef PRNG_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!res) begin
      r_cnt <= 8'd0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_err <= w_err_nxt;
    end
  end

  assign err = r_err;
`endif

  // A withdrawn request simply masks the strobe; the byte is dropped.
  assign valid    = (r_state == DELIVER) ? (r_gnt & req) : '0;
  assign gnt      = r_gnt;
  assign dout     = r_dout;
  assign prng_ena = r_ena;
  assign prng_res = r_prng_res;

endmodule

// File: tb/tb_prng_arbiter.sv
// Directed bench for prng_arbiter (N=4); the generator is modelled by driving
// prng_dout/prng_done directly. Timeout scenario runs only with PRNG_ARB_TIMEOUT_EN.
module tb_prng_arbiter;

  logic       clk = 1'b0;
  logic       res;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [3:0] valid;
  logic [7:0] dout;
  logic       prng_ena;
  logic       prng_res;
  logic [7:0] prng_dout;
  logic       prng_done;
`ifdef PRNG_ARB_TIMEOUT_EN
  logic       err;
`endif

  int nvec = 0;
  int nerr = 0;

  prng_arbiter #(.N(4), .TIMEOUT(64)) dut (
    .clk       (clk),
    .res       (res),
    .req       (req),
    .gnt       (gnt),
    .valid     (valid),
    .dout      (dout),
    .prng_ena  (prng_ena),
    .prng_res  (prng_res),
`ifdef PRNG_ARB_TIMEOUT_EN
    .err       (err),
`endif
    .prng_dout (prng_dout),
    .prng_done (prng_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    res = 1'b0; req = 4'b0000; prng_done = 1'b0; prng_dout = 8'h00;
    tick(); tick();
    nvec++;
    if (gnt !== 4'b0000 || valid !== 4'b0000 || dout !== 8'h00 ||
        prng_ena !== 1'b0 || prng_res !== 1'b1) begin
      nerr++;
      $display("FAIL reset_vals: gnt=%b valid=%b dout=%h ena=%b pres=%b, want 0000 0000 00 0 1",
               gnt, valid, dout, prng_ena, prng_res);
    end
`ifdef PRNG_ARB_TIMEOUT_EN
    nvec++;
    if (err !== 1'b0) begin nerr++; $display("FAIL reset_err: got %b want 0", err); end
`endif
    res = 1'b1;
    nvec++;
    if (prng_res !== 1'b1) begin
      nerr++; $display("FAIL pres_first_cycle: got %b want 1", prng_res);
    end
    tick();
    nvec++;
    if (prng_res !== 1'b0) begin
      nerr++; $display("FAIL pres_released: got %b want 0", prng_res);
    end
  endtask

  task automatic test_first_byte();
    req = 4'b0001;
    tick();
    nvec++;
    if (gnt !== 4'b0001 || prng_ena !== 1'b1) begin
      nerr++; $display("FAIL first_grant: gnt=%b ena=%b want 0001 1", gnt, prng_ena);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      nvec++;
      if (prng_ena !== 1'b1 || valid !== 4'b0000 || gnt !== 4'b0001) begin
        nerr++;
        $display("FAIL first_fill cyc%0d: ena=%b valid=%b gnt=%b want 1 0000 0001",
                 i, prng_ena, valid, gnt);
      end
    end
    prng_dout = 8'hA5; prng_done = 1'b1;
    tick();
    nvec++;
    if (valid !== 4'b0001 || dout !== 8'hA5 || prng_ena !== 1'b0) begin
      nerr++;
      $display("FAIL first_deliver: valid=%b dout=%h ena=%b want 0001 a5 0", valid, dout, prng_ena);
    end
    req = 4'b0000; prng_done = 1'b0;
    tick();
    nvec++;
    if (gnt !== 4'b0000 || valid !== 4'b0000 || dout !== 8'hA5) begin
      nerr++; $display("FAIL first_idle: gnt=%b valid=%b dout=%h want 0000 0000 a5", gnt, valid, dout);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [4];
    logic [7:0] b;
    exp_g[0] = 4'b0010; exp_g[1] = 4'b0100; exp_g[2] = 4'b1000; exp_g[3] = 4'b0001;
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      b = 8'h10 + 8'(k);
      tick();
      nvec++;
      if (gnt !== exp_g[k] || prng_ena !== 1'b1) begin
        nerr++; $display("FAIL rr_grant%0d: gnt=%b ena=%b want %b 1", k, gnt, prng_ena, exp_g[k]);
      end
      prng_dout = b; prng_done = 1'b1;
      tick();
      nvec++;
      if (valid !== exp_g[k] || dout !== b || gnt !== exp_g[k]) begin
        nerr++;
        $display("FAIL rr_deliver%0d: valid=%b dout=%h gnt=%b want %b %h %b",
                 k, valid, dout, gnt, exp_g[k], b, exp_g[k]);
      end
      prng_done = 1'b0;
      if (k == 3) req = 4'b0000;
      tick();
      nvec++;
      if (gnt !== 4'b0000 || prng_ena !== 1'b0 || valid !== 4'b0000) begin
        nerr++; $display("FAIL rr_idle%0d: gnt=%b ena=%b valid=%b want 0000 0 0000", k, gnt, prng_ena, valid);
      end
    end
  endtask

  task automatic test_stale_done();
    prng_done = 1'b1; prng_dout = 8'h11; req = 4'b0010;
    tick();
    nvec++;
    if (gnt !== 4'b0010 || prng_ena !== 1'b1) begin
      nerr++; $display("FAIL stale_grant: gnt=%b ena=%b want 0010 1", gnt, prng_ena);
    end
    tick();
    nvec++;
    if (valid !== 4'b0000 || dout !== 8'h13 || prng_ena !== 1'b1) begin
      nerr++; $display("FAIL stale_ignored: valid=%b dout=%h ena=%b want 0000 13 1", valid, dout, prng_ena);
    end
    prng_done = 1'b0;
    tick();
    nvec++;
    if (dout !== 8'h13 || prng_ena !== 1'b1) begin
      nerr++; $display("FAIL stale_low: dout=%h ena=%b want 13 1", dout, prng_ena);
    end
    prng_done = 1'b1; prng_dout = 8'h22;
    tick();
    nvec++;
    if (valid !== 4'b0010 || dout !== 8'h22) begin
      nerr++; $display("FAIL stale_fresh: valid=%b dout=%h want 0010 22", valid, dout);
    end
    req = 4'b0000; prng_done = 1'b0;
    tick();
    nvec++;
    if (gnt !== 4'b0000 || dout !== 8'h22) begin
      nerr++; $display("FAIL stale_idle: gnt=%b dout=%h want 0000 22", gnt, dout);
    end
  endtask

  task automatic test_withdraw();
    req = 4'b1100;
    tick();
    nvec++;
    if (gnt !== 4'b0100) begin
      nerr++; $display("FAIL wd_grant: gnt=%b want 0100", gnt);
    end
    req = 4'b1011;
    tick();
    nvec++;
    if (gnt !== 4'b0100 || prng_ena !== 1'b1) begin
      nerr++; $display("FAIL wd_hold: gnt=%b ena=%b want 0100 1", gnt, prng_ena);
    end
    prng_dout = 8'h5A; prng_done = 1'b1;
    tick();
    nvec++;
    if (valid !== 4'b0000) begin
      nerr++; $display("FAIL wd_discard: valid=%b want 0000", valid);
    end
    prng_done = 1'b0;
    tick();
    nvec++;
    if (gnt !== 4'b0000) begin
      nerr++; $display("FAIL wd_idle: gnt=%b want 0000", gnt);
    end
    tick();
    nvec++;
    if (gnt !== 4'b1000) begin
      nerr++; $display("FAIL wd_next: gnt=%b want 1000", gnt);
    end
    prng_dout = 8'h66; prng_done = 1'b1;
    tick();
    nvec++;
    if (valid !== 4'b1000 || dout !== 8'h66) begin
      nerr++; $display("FAIL wd_next_deliver: valid=%b dout=%h want 1000 66", valid, dout);
    end
    req = 4'b0000; prng_done = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    req = 4'b0100;
    tick();
    nvec++;
    if (gnt !== 4'b0100) begin
      nerr++; $display("FAIL rm_grant: gnt=%b want 0100", gnt);
    end
    tick();
    res = 1'b0;
    tick();
    nvec++;
    if (gnt !== 4'b0000 || prng_ena !== 1'b0 || prng_res !== 1'b1 ||
        dout !== 8'h00 || valid !== 4'b0000) begin
      nerr++;
      $display("FAIL rm_reset: gnt=%b ena=%b pres=%b dout=%h valid=%b want 0000 0 1 00 0000",
               gnt, prng_ena, prng_res, dout, valid);
    end
    prng_dout = 8'h99; prng_done = 1'b1;
    res = 1'b1;
    tick();
    nvec++;
    if (gnt !== 4'b0000 || valid !== 4'b0000 || prng_res !== 1'b0) begin
      nerr++; $display("FAIL rm_release: gnt=%b valid=%b pres=%b want 0000 0000 0", gnt, valid, prng_res);
    end
    prng_done = 1'b0;
    req = 4'b0101;
    tick();
    nvec++;
    if (gnt !== 4'b0001) begin
      nerr++; $display("FAIL rm_ptr_reset: gnt=%b want 0001", gnt);
    end
    prng_dout = 8'h77; prng_done = 1'b1;
    tick();
    nvec++;
    if (valid !== 4'b0001 || dout !== 8'h77) begin
      nerr++; $display("FAIL rm_deliver: valid=%b dout=%h want 0001 77", valid, dout);
    end
    req = 4'b0000; prng_done = 1'b0;
    tick();
  endtask

`ifdef PRNG_ARB_TIMEOUT_EN
  task automatic test_timeout();
    req = 4'b0010;
    tick();
    nvec++;
    if (gnt !== 4'b0010) begin
      nerr++; $display("FAIL to_grant: gnt=%b want 0010", gnt);
    end
    for (int i = 1; i < 64; i++) begin
      tick();
      nvec++;
      if (err !== 1'b0 || gnt !== 4'b0010 || prng_ena !== 1'b1) begin
        nerr++; $display("FAIL to_wait%0d: err=%b gnt=%b ena=%b want 0 0010 1", i, err, gnt, prng_ena);
      end
    end
    tick();
    nvec++;
    if (err !== 1'b1 || prng_res !== 1'b1 || gnt !== 4'b0000 ||
        prng_ena !== 1'b0 || valid !== 4'b0000) begin
      nerr++;
      $display("FAIL to_fire: err=%b pres=%b gnt=%b ena=%b valid=%b want 1 1 0000 0 0000",
               err, prng_res, gnt, prng_ena, valid);
    end
    req = 4'b0000;
    tick();
    nvec++;
    if (err !== 1'b0 || prng_res !== 1'b0 || gnt !== 4'b0000) begin
      nerr++; $display("FAIL to_after: err=%b pres=%b gnt=%b want 0 0 0000", err, prng_res, gnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first_byte();
    test_round_robin();
    test_stale_done();
    test_withdraw();
    test_reset_mid();
`ifdef PRNG_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
